// File: rtl/binary_decoder_nb_seq_if.sv
// Control and decoded-output bundle for binary_decoder_nb_seq.
// The master drives the select and mode. The slave (the decoder) returns the registered outputs.
interface binary_decoder_nb_seq_if #(
  parameter int N = 4
);
  logic              en;
  logic [1:0]        mode;
  logic [N-1:0]      sel;
  logic [(1<<N)-1:0] out;
  logic [N-1:0]      idx;
  logic              step;

  modport master (output en, mode, sel, input out, idx, step);
  modport slave  (input en, mode, sel, output out, idx, step);
endinterface

// File: rtl/binary_decoder_nb_seq.sv
// N-to-2**N decoder with a registered output.
// Supports direct, thermometer, wrap-scan and bounce-scan modes, and pulses step on each scan advance.
module binary_decoder_nb_seq #(
  parameter int N   = 4,
  parameter int DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  binary_decoder_nb_seq_if.slave    bus
);
  localparam int W  = 1 << N;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [W-1:0]  ONE      = W'(1);
  localparam logic [W-1:0]  ONES     = '1;
  localparam logic [N-1:0]  IDX_MAX  = '1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DIV - 1);

  logic [W-1:0]  out_q,  out_d;
  logic [N-1:0]  idx_q,  idx_d;
  logic          step_q, step_d;
  logic [DW-1:0] cnt_q,  cnt_d;
  logic          dir_q,  dir_d;
  logic [1:0]    mode_q, mode_d;

  always_comb begin
    out_d  = '0;
    step_d = 1'b0;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (bus.en) begin
      mode_d = bus.mode;
      unique case (bus.mode)
        MODE_DIRECT: begin
          idx_d = bus.sel;
          out_d = ONE << bus.sel;
          cnt_d = '0;
        end
        MODE_THERM: begin
          idx_d = bus.sel;
          // Mask of bits sel+1 and up, inverted. The top bit falls off the end, so sel=max gives all ones.
          out_d = ~((ONES << bus.sel) << 1);
          cnt_d = '0;
        end
        default: begin
          if (bus.mode != mode_q) begin
            cnt_d = '0;
            if (bus.mode == MODE_BOUNCE) dir_d = DIR_UP;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            step_d = 1'b1;
            if (bus.mode == MODE_SCAN) begin
              idx_d = idx_q + N'(1);
            end else if (dir_q == DIR_UP) begin
              if (idx_q == IDX_MAX) begin
                idx_d = idx_q - N'(1);
                dir_d = DIR_DOWN;
              end else begin
                idx_d = idx_q + N'(1);
              end
            end else begin
              if (idx_q == '0) begin
                idx_d = N'(1);
                dir_d = DIR_UP;
              end else begin
                idx_d = idx_q - N'(1);
              end
            end
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
          out_d = ONE << idx_d;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      idx_q  <= '0;
      step_q <= 1'b0;
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      mode_q <= MODE_DIRECT;
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.step = step_q;
endmodule

// File: tb/tb_binary_decoder_nb_seq.sv
// Bench for binary_decoder_nb_seq: directed sweeps followed by random stimulus.
// Two instances (N=4/DIV=4 and N=3/DIV=1) are checked against a reference model.
module tb_binary_decoder_nb_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  binary_decoder_nb_seq_if #(.N(4)) if0 ();
  binary_decoder_nb_seq_if #(.N(3)) if1 ();

  binary_decoder_nb_seq #(.N(4), .DIV(4)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  binary_decoder_nb_seq #(.N(3), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // Bounce is modelled as a phase p on a ping-pong cycle of length 2*(2**N-1).
  typedef struct {
    int     idx;
    int     p;
    int     cnt;
    int     mode;
    longint out;
    int     step;
  } model_t;

  model_t m0, m1;

  function automatic model_t mstep(model_t s, int n, int div, bit en, int md, int sel);
    model_t r = s;
    int w = 1 << n;
    int m = w - 1;
    r.step = 0;
    if (!en) begin
      r.out = 0;
      return r;
    end
    r.mode = md;
    if (md == 0) begin
      r.idx = sel; r.out = longint'(1) << sel; r.cnt = 0;
    end else if (md == 1) begin
      r.idx = sel; r.out = (longint'(1) << (sel + 1)) - 1; r.cnt = 0;
    end else begin
      if (md != s.mode) begin
        r.cnt = 0;
        r.p   = s.idx;
      end else begin
        r.cnt = s.cnt + 1;
        if (r.cnt == div) begin
          r.cnt  = 0;
          r.step = 1;
          if (md == 2) begin
            r.idx = (s.idx + 1) % w;
          end else begin
            r.p   = (s.p + 1) % (2 * m);
            r.idx = (r.p <= m) ? r.p : 2 * m - r.p;
          end
        end
      end
      r.out = longint'(1) << r.idx;
    end
    return r;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out0",  longint'(if0.out),  m0.out);
    check("idx0",  longint'(if0.idx),  longint'(m0.idx));
    check("step0", longint'(if0.step), longint'(m0.step));
    check("out1",  longint'(if1.out),  m1.out);
    check("idx1",  longint'(if1.idx),  longint'(m1.idx));
    check("step1", longint'(if1.step), longint'(m1.step));
  endtask

  task automatic drive(input bit e, input int md, input int s);
    if0.en = e; if0.mode = 2'(md); if0.sel = 4'(s);
    if1.en = e; if1.mode = 2'(md); if1.sel = 3'(s);
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = mstep(m0, 4, 4, if0.en, int'(if0.mode), int'(if0.sel));
    m1 = mstep(m1, 3, 1, if1.en, int'(if1.mode), int'(if1.sel));
    #1;
    check_all();
  endtask

  task automatic run(input bit e, input int md, input int s, input int cycles);
    drive(e, md, s);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    reset = 1'b1;
    drive(1'b1, 2, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #3 reset = 1'b0;

    for (int s = 0; s < 16; s++) run(1'b1, 0, s, 1);
    for (int s = 0; s < 16; s++) run(1'b0, 0, s, 1);
    run(1'b1, 1, 0, 1);
    run(1'b1, 1, 5, 1);
    run(1'b1, 1, 15, 1);

    run(1'b1, 0, 0, 1);
    run(1'b1, 2, 3, 70);
    run(1'b0, 2, 3, 3);
    run(1'b1, 2, 3, 10);

    run(1'b1, 0, 9, 1);
    run(1'b1, 2, 0, 2);
    run(1'b1, 3, 0, 40);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) drive(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if0.en = ($urandom_range(0, 7) != 0);
      if1.en = if0.en;
      if (if0.mode < 2) begin
        if0.sel = 4'($urandom_range(0, 15));
        if1.sel = 3'(if0.sel);
      end
      tick();
    end

    run(1'b1, 3, 0, 13);
    #2 reset = 1'b1;
    #1;
    m0 = '{default: 0};
    m1 = '{default: 0};
    check_all();
    #2 reset = 1'b0;
    run(1'b1, 3, 0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
